// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, sequencer state encoding and
// the bit layout of the flag byte returned after each operation.
`timescale 1ns/1ps

package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    // Bit positions inside the flag byte.
    localparam int FLG_CARRY_BIT   = 0;
    localparam int FLG_ILLEGAL_BIT = 1;

    typedef enum logic [2:0] {
        WAIT_A   = 3'd0,
        WAIT_B   = 3'd1,
        WAIT_OP  = 3'd2,
        EXEC     = 3'd3,
        SEND_RES = 3'd4,
        SEND_FLG = 3'd5
    } seq_state_t;

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tx_byte_issuer.sv
// Hands one byte at a time to the UART transmitter: one-cycle start pulse,
// data held until the transmitter reports completion.
`timescale 1ns/1ps

module tx_byte_issuer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue,
    input  logic [DATA_W-1:0] issue_data,
    input  logic              tx_done,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    output logic              accept
);

    logic waiting_q;

    // A done pulse coincident with our own start pulse belongs to nothing we sent.
    assign accept = waiting_q && tx_done && !tx_start;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data   <= '0;
            tx_start  <= 1'b0;
            waiting_q <= 1'b0;
        end else begin
            tx_start <= issue;
            if (issue) begin
                tx_data   <= issue_data;
                waiting_q <= 1'b1;
            end else if (accept) begin
                waiting_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_uart_sequencer.sv
// UART byte-stream front end for the ALU: gathers A, B and opcode, runs one
// EXEC cycle, then returns the result byte and the flag byte.
`timescale 1ns/1ps

module alu_uart_sequencer
    import alu_pkg::*;
#(
    parameter int SIZE   = 8,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_rx_valid,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_tx_start,
    input  logic              i_tx_done,
    output logic [SIZE-1:0]   o_a_alu,
    output logic [SIZE-1:0]   o_b_alu,
    output logic [5:0]        o_opcode_alu,
    input  logic [SIZE-1:0]   i_res_alu,
    input  logic              i_carry_alu,
    output logic              o_busy
);

    seq_state_t        state_q, state_d;
    logic              load_a, load_b, load_op, exec;
    logic              issue, tx_accept, legal;
    logic [DATA_W-1:0] issue_data, res_ext, flg_d, flg_q;

    assign legal   = is_legal(o_opcode_alu);
    assign res_ext = legal ? DATA_W'($signed(i_res_alu)) : '0;

    always_comb begin
        flg_d                  = '0;
        flg_d[FLG_ILLEGAL_BIT] = !legal;
        flg_d[FLG_CARRY_BIT]   = legal & i_carry_alu;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= WAIT_A;
        else          state_q <= state_d;
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_A:   if (i_rx_valid) state_d = WAIT_B;
            WAIT_B:   if (i_rx_valid) state_d = WAIT_OP;
            WAIT_OP:  if (i_rx_valid) state_d = EXEC;
            EXEC:                     state_d = SEND_RES;
            SEND_RES: if (tx_accept)  state_d = SEND_FLG;
            SEND_FLG: if (tx_accept)  state_d = WAIT_A;
            default:                  state_d = WAIT_A;
        endcase
    end

    // The result byte is handed to the issuer at the EXEC edge so its start
    // pulse lands on the first SEND_RES cycle.
    always_comb begin
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_op    = 1'b0;
        exec       = 1'b0;
        issue      = 1'b0;
        issue_data = flg_q;
        o_busy     = 1'b0;
        case (state_q)
            WAIT_A:  load_a  = i_rx_valid;
            WAIT_B:  load_b  = i_rx_valid;
            WAIT_OP: load_op = i_rx_valid;
            EXEC: begin
                exec       = 1'b1;
                issue      = 1'b1;
                issue_data = res_ext;
                o_busy     = 1'b1;
            end
            SEND_RES: begin
                issue  = tx_accept;
                o_busy = 1'b1;
            end
            SEND_FLG: o_busy = 1'b1;
            default: ;
        endcase
    end

    // Operands persist across sequences; only a new byte overwrites them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_a_alu      <= '0;
            o_b_alu      <= '0;
            o_opcode_alu <= '0;
            flg_q        <= '0;
        end else begin
            if (load_a)  o_a_alu      <= i_rx_data[SIZE-1:0];
            if (load_b)  o_b_alu      <= i_rx_data[SIZE-1:0];
            if (load_op) o_opcode_alu <= i_rx_data[5:0];
            if (exec)    flg_q        <= flg_d;
        end
    end

    tx_byte_issuer #(.DATA_W(DATA_W)) u_tx_issuer (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .issue      (issue),
        .issue_data (issue_data),
        .tx_done    (i_tx_done),
        .tx_data    (o_tx_data),
        .tx_start   (o_tx_start),
        .accept     (tx_accept)
    );

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed bench for alu_uart_sequencer: an 8-bit and a 4-bit instance, each
// driven by a small behavioural ALU, with hand-computed byte expectations.
`timescale 1ns/1ps

module tb_alu_uart_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid8 = 1'b0, rx_valid4 = 1'b0;
    logic       tx_done = 1'b0;

    logic [7:0] tx_data8, tx_data4;
    logic       tx_start8, tx_start4, busy8, busy4;
    logic [7:0] a8, b8, res8;
    logic [3:0] a4, b4, res4;
    logic [5:0] op8, op4;
    logic       carry8, carry4;
    logic [8:0] m8, m4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_uart_sequencer #(.SIZE(8), .DATA_W(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid8),
        .o_tx_data(tx_data8), .o_tx_start(tx_start8), .i_tx_done(tx_done),
        .o_a_alu(a8), .o_b_alu(b8), .o_opcode_alu(op8),
        .i_res_alu(res8), .i_carry_alu(carry8), .o_busy(busy8)
    );

    alu_uart_sequencer #(.SIZE(4), .DATA_W(8)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid4),
        .o_tx_data(tx_data4), .o_tx_start(tx_start4), .i_tx_done(tx_done),
        .o_a_alu(a4), .o_b_alu(b4), .o_opcode_alu(op4),
        .i_res_alu(res4), .i_carry_alu(carry4), .o_busy(busy4)
    );

    // Behavioural ALU of width w: returns {signed overflow, result}.
    function automatic logic [8:0] alu_f(input int w, input logic [7:0] a,
                                         input logic [7:0] b, input logic [5:0] op);
        int  va, vb, r, mask, maxv;
        logic c;
        mask = (1 << w) - 1;
        maxv = mask >> 1;
        va = int'(a);
        vb = int'(b);
        if (a[w-1]) va -= (1 << w);
        if (b[w-1]) vb -= (1 << w);
        c = 1'b0;
        case (op)
            6'b100000: begin r = va + vb; c = (r > maxv) || (r < -(maxv + 1)); end
            6'b100010: begin r = va - vb; c = (r > maxv) || (r < -(maxv + 1)); end
            6'b100100: r = va & vb;
            6'b100101: r = va | vb;
            6'b100110: r = va ^ vb;
            6'b100111: r = ~(va | vb);
            6'b000011: r = va >>> 1;
            6'b000010: r = int'(a) >> 1;
            default:   r = 0;
        endcase
        return {c, 8'(r & mask)};
    endfunction

    always_comb begin
        m8 = alu_f(8, a8, b8, op8);
        m4 = alu_f(4, {4'b0, a4}, {4'b0, b4}, op4);
    end
    assign res8   = m8[7:0];
    assign carry8 = m8[8];
    assign res4   = m4[3:0];
    assign carry4 = m4[8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic get_start(input bit sel);
        return sel ? tx_start4 : tx_start8;
    endfunction
    function automatic logic [7:0] get_data(input bit sel);
        return sel ? tx_data4 : tx_data8;
    endfunction
    function automatic logic get_busy(input bit sel);
        return sel ? busy4 : busy8;
    endfunction
    function automatic logic [7:0] get_a(input bit sel);
        return sel ? {4'b0, a4} : a8;
    endfunction
    function automatic logic [7:0] get_b(input bit sel);
        return sel ? {4'b0, b4} : b8;
    endfunction
    function automatic logic [5:0] get_op(input bit sel);
        return sel ? op4 : op8;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] v);
        tick();
        rx_data = v;
        if (sel) rx_valid4 = 1'b1;
        else     rx_valid8 = 1'b1;
        tick();
        rx_valid8 = 1'b0;
        rx_valid4 = 1'b0;
    endtask

    task automatic pulse_done();
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    // Waits (bounded) for a start pulse; n counts cycles from the caller's position.
    task automatic wait_start(input bit sel, input int n0, output int n);
        n = n0;
        while (!get_start(sel) && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic run_seq(input bit sel, input string tag,
                           input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] bop,
                           input logic [7:0] exp_a, input logic [7:0] exp_b, input logic [5:0] exp_op,
                           input logic [7:0] exp_res, input logic [7:0] exp_flg,
                           input bit stop_in_flg);
        int n;
        send_byte(sel, ba);
        send_byte(sel, bb);
        send_byte(sel, bop);
        check({tag, ".a"}, get_a(sel), exp_a);
        check({tag, ".b"}, get_b(sel), exp_b);
        check({tag, ".op"}, get_op(sel), exp_op);
        check({tag, ".busy_exec"}, get_busy(sel), 1);
        wait_start(sel, 1, n);
        check({tag, ".latency"}, n, 2);
        check({tag, ".res"}, get_data(sel), exp_res);
        tick();
        tick();
        check({tag, ".res_held"}, get_data(sel), exp_res);
        pulse_done();
        wait_start(sel, 0, n);
        check({tag, ".flg_start"}, get_start(sel), 1);
        check({tag, ".flg"}, get_data(sel), exp_flg);
        if (!stop_in_flg) begin
            pulse_done();
            tick();
            check({tag, ".idle"}, get_busy(sel), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;

        // Reset values
        tick();
        check("rst.tx_data", tx_data8, 8'h00);
        check("rst.tx_start", tx_start8, 0);
        check("rst.busy", busy8, 0);
        check("rst.ab", {a8, b8}, 16'h0000);
        check("rst.op", op8, 6'h00);
        check("rst4.ab", {a4, b4}, 8'h00);
        #2 rst_n = 1'b1;
        tick();

        run_seq(0, "add", 8'h05, 8'h03, 8'h20, 8'h05, 8'h03, 6'h20, 8'h08, 8'h00, 0);
        run_seq(0, "illegal", 8'h01, 8'h02, 8'h3F, 8'h01, 8'h02, 6'h3F, 8'h00, 8'h02, 0);
        run_seq(0, "sra8", 8'hF0, 8'h00, 8'h03, 8'hF0, 8'h00, 6'h03, 8'hF8, 8'h00, 0);

        // Busy-time rx byte and a done pulse coincident with the start pulse
        send_byte(0, 8'h03);
        send_byte(0, 8'h04);
        send_byte(0, 8'h25);
        tick();
        check("inj.start", tx_start8, 1);
        check("inj.res", tx_data8, 8'h07);
        rx_data   = 8'hAA;
        rx_valid8 = 1'b1;
        tx_done   = 1'b1;
        tick();
        rx_valid8 = 1'b0;
        tx_done   = 1'b0;
        check("inj.no_early_flg", tx_start8, 0);
        check("inj.held", tx_data8, 8'h07);
        check("inj.a_kept", a8, 8'h03);
        check("inj.busy", busy8, 1);
        tick();
        check("inj.still_res", tx_data8, 8'h07);
        pulse_done();
        wait_start(0, 0, n);
        check("inj.flg_start", tx_start8, 1);
        check("inj.flg", tx_data8, 8'h00);
        pulse_done();

        run_seq(0, "sub", 8'h02, 8'h02, 8'h22, 8'h02, 8'h02, 6'h22, 8'h00, 8'h00, 0);

        // Carry, then reset while the flag byte is outstanding
        run_seq(0, "carry", 8'h7F, 8'h01, 8'h20, 8'h7F, 8'h01, 6'h20, 8'h80, 8'h01, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst.tx_data", tx_data8, 8'h00);
        check("mid_rst.tx_start", tx_start8, 0);
        check("mid_rst.busy", busy8, 0);
        check("mid_rst.ab", {a8, b8}, 16'h0000);
        check("mid_rst.op", op8, 6'h00);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (tx_start8) seen = 1'b1;
        end
        check("mid_rst.no_resend", seen, 0);

        run_seq(0, "and", 8'h01, 8'h01, 8'h24, 8'h01, 8'h01, 6'h24, 8'h01, 8'h00, 0);

        // 4-bit instance: sign extension, and opcode bits [7:6] ignored
        run_seq(1, "sra4", 8'h08, 8'h00, 8'h03, 8'h08, 8'h00, 6'h03, 8'hFC, 8'h00, 0);
        run_seq(1, "add4_hi", 8'h03, 8'h04, 8'hE0, 8'h03, 8'h04, 6'h20, 8'h07, 8'h00, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
